tile_renderer: RTL and testbench

// Tilemap pixel generator; sits upstream of the map and tile BRAMs and consumes their

---
 rtl/tile_renderer.sv | 217 +++++++++++++++++++++
 tb/tb_tile_renderer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - tilemap pixel generator: map/tile BRAM fetch, one-column lookahead, 2bpp shift-out.
// Optional TILE_RENDERER_SCROLL_EN adds per-line scroll_x_i/scroll_y_i ports.
module tile_renderer #(
    parameter int MAP_W_LOG2 = 5,
    parameter int MAP_H_LOG2 = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             frame_start_i,
    input  logic                             line_start_i,
    input  logic                             pix_en_i,
`ifdef TILE_RENDERER_SCROLL_EN
    input  logic [MAP_W_LOG2+2:0]            scroll_x_i,
    input  logic [MAP_H_LOG2+2:0]            scroll_y_i,
`endif
    output logic [MAP_W_LOG2+MAP_H_LOG2-1:0] map_addr_o,
    input  logic [7:0]                       map_data_i,
    output logic [10:0]                      tile_addr_o,
    input  logic [15:0]                      tile_data_i,
    output logic [1:0]                       pixel_o,
    output logic                             pixel_valid_o,
    output logic                             underrun_o
);
    localparam int XW = MAP_W_LOG2 + 3;
    localparam int YW = MAP_H_LOG2 + 3;
    localparam int AW = MAP_W_LOG2 + MAP_H_LOG2;

    typedef enum logic [1:0] {F_IDLE, F_MAP, F_TILE, F_LOAD} fstate_t;

    localparam logic [1:0] PF_NONE  = 2'd0;
    localparam logic [1:0] PF_FIRST = 2'd1;
    localparam logic [1:0] PF_AHEAD = 2'd2;

    fstate_t               state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [2:0]            sx_fine_q, sx_fine_d;
    logic [YW-1:0]         sy_q, sy_d;
    logic [MAP_W_LOG2-1:0] fcol_q, fcol_d;
    logic [1:0]            pf_q, pf_d;
    logic                  active_q, active_d;
    logic [15:0]           next_buf_q, next_buf_d;
    logic                  next_valid_q, next_valid_d;
    logic [15:0]           shift_q, shift_d;
    logic [2:0]            phase_q, phase_d;
    logic [AW-1:0]         map_addr_q, map_addr_d;
    logic [10:0]           tile_addr_q, tile_addr_d;
    logic [1:0]            pixel_q, pixel_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  underrun_q, underrun_d;

    logic [XW-1:0]         sx_in;
    logic [YW-1:0]         sy_in;
    logic                  start;
    logic [YW-1:0]         y_next;
    logic [YW-1:0]         sy_next;
    logic [YW-1:0]         y_sum;
    logic [10:0]           tile_addr_live;
    logic                  fetch_go;
    logic [MAP_W_LOG2-1:0] fetch_col;

`ifdef TILE_RENDERER_SCROLL_EN
    assign sx_in = scroll_x_i;
    assign sy_in = scroll_y_i;
`else
    assign sx_in = '0;
    assign sy_in = '0;
`endif

    assign start   = frame_start_i | line_start_i;
    assign y_next  = frame_start_i ? '0 : (line_start_i ? y_q + 1'b1 : y_q);
    assign sy_next = start ? sy_in : sy_q;
    // Effective line for whichever fetch is issued or in flight this cycle.
    assign y_sum          = y_next + sy_next;
    assign tile_addr_live = {map_data_i, y_sum[2:0]};

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_next;
        sx_fine_d     = sx_fine_q;
        sy_d          = sy_next;
        fcol_d        = fcol_q;
        pf_d          = pf_q;
        active_d      = active_q;
        next_buf_d    = next_buf_q;
        next_valid_d  = next_valid_q;
        shift_d       = shift_q;
        phase_d       = phase_q;
        map_addr_d    = map_addr_q;
        tile_addr_d   = tile_addr_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        underrun_d    = underrun_q;
        fetch_go      = 1'b0;
        fetch_col     = fcol_q + 1'b1;

        if (start) begin
            x_d          = '0;
            sx_fine_d    = sx_in[2:0];
            active_d     = 1'b1;
            pf_d         = PF_FIRST;
            next_valid_d = 1'b0;
            shift_d      = '0;
            phase_d      = '0;
            if (frame_start_i) begin
                underrun_d = 1'b0;
            end
            fetch_go  = 1'b1;
            fetch_col = sx_in[XW-1:3];
        end else begin
            case (state_q)
                F_MAP:   state_d = F_TILE;
                F_TILE: begin
                    state_d     = F_LOAD;
                    tile_addr_d = tile_addr_live;
                end
                F_LOAD:  state_d = F_IDLE;
                default: state_d = F_IDLE;
            endcase

            if (state_q == F_LOAD) begin
                if (pf_q == PF_FIRST) begin
                    // First column goes straight to the shifter, pre-shifted by fine scroll.
                    shift_d  = tile_data_i << {sx_fine_q, 1'b0};
                    phase_d  = sx_fine_q;
                    pf_d     = PF_AHEAD;
                    fetch_go = 1'b1;
                end else begin
                    next_buf_d   = tile_data_i;
                    next_valid_d = 1'b1;
                    pf_d         = PF_NONE;
                end
            end

            if (pix_en_i && active_q) begin
                x_d           = x_q + 1'b1;
                pixel_valid_d = 1'b1;
                if (pf_q != PF_NONE) begin
                    pixel_d    = 2'b00;
                    underrun_d = 1'b1;
                end else begin
                    pixel_d = shift_q[15:14];
                    if (phase_q == 3'd7) begin
                        phase_d = '0;
                        if (next_valid_q) begin
                            shift_d = next_buf_q;
                        end else begin
                            shift_d    = '0;
                            underrun_d = 1'b1;
                        end
                        // A fetch landing now already targets the following column; keep it.
                        if (state_q != F_LOAD) begin
                            next_valid_d = 1'b0;
                            fetch_go     = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q << 2;
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
        end

        if (fetch_go) begin
            state_d    = F_MAP;
            fcol_d     = fetch_col;
            map_addr_d = {y_sum[YW-1:3], fetch_col};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= F_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            sx_fine_q     <= '0;
            sy_q          <= '0;
            fcol_q        <= '0;
            pf_q          <= PF_NONE;
            active_q      <= 1'b0;
            next_buf_q    <= '0;
            next_valid_q  <= 1'b0;
            shift_q       <= '0;
            phase_q       <= '0;
            map_addr_q    <= '0;
            tile_addr_q   <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            sx_fine_q     <= sx_fine_d;
            sy_q          <= sy_d;
            fcol_q        <= fcol_d;
            pf_q          <= pf_d;
            active_q      <= active_d;
            next_buf_q    <= next_buf_d;
            next_valid_q  <= next_valid_d;
            shift_q       <= shift_d;
            phase_q       <= phase_d;
            map_addr_q    <= map_addr_d;
            tile_addr_q   <= tile_addr_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            underrun_q    <= underrun_d;
        end
    end

    assign map_addr_o    = map_addr_q;
    assign tile_addr_o   = (state_q == F_TILE) ? tile_addr_live : tile_addr_q;
    assign pixel_o       = pixel_q;
    assign pixel_valid_o = pixel_valid_q;
    assign underrun_o    = underrun_q;
endmodule

// File: tb/tb_tile_renderer.sv
// tb/tb_tile_renderer.sv - self-checking bench for tile_renderer with BRAM models and a screen-space pixel model.
module tb_tile_renderer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs = 1'b0;
    logic        ls = 1'b0;
    logic        pix_en = 1'b0;
    logic [8:0]  map_addr;
    logic [7:0]  map_data = '0;
    logic [10:0] tile_addr;
    logic [15:0] tile_data = '0;
    logic [1:0]  pixel;
    logic        pixel_valid;
    logic        underrun;
`ifdef TILE_RENDERER_SCROLL_EN
    logic [7:0]  scroll_x = '0;
    logic [6:0]  scroll_y = '0;
`endif

    logic [7:0]  map_mem [512];
    logic [15:0] tile_mem [2048];

    int total = 0;
    int bad = 0;
    int ly = 0;
    int sx = 0;
    int sy = 0;

    tile_renderer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_start_i (fs),
        .line_start_i  (ls),
        .pix_en_i      (pix_en),
`ifdef TILE_RENDERER_SCROLL_EN
        .scroll_x_i    (scroll_x),
        .scroll_y_i    (scroll_y),
`endif
        .map_addr_o    (map_addr),
        .map_data_i    (map_data),
        .tile_addr_o   (tile_addr),
        .tile_data_i   (tile_data),
        .pixel_o       (pixel),
        .pixel_valid_o (pixel_valid),
        .underrun_o    (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        map_data  <= map_mem[map_addr];
        tile_data <= tile_mem[tile_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel i of the current line, from screen geometry alone.
    function automatic logic [31:0] exp_pix(input int i);
        int xe;
        int ye;
        int idx;
        logic [15:0] row;
        xe  = (sx + i) % 256;
        ye  = (ly + sy) % 128;
        idx = map_mem[(ye / 8) * 32 + xe / 8];
        row = tile_mem[idx * 8 + ye % 8];
        return 32'((row >> (14 - 2 * (xe % 8))) & 16'h3);
    endfunction

    task automatic do_start(input bit is_frame);
        int ye;
        int ma;
        pix_en = 1'b0;
        if (is_frame) begin
            fs = 1'b1;
            ly = 0;
        end else begin
            ls = 1'b1;
            ly = (ly + 1) % 128;
        end
`ifdef TILE_RENDERER_SCROLL_EN
        scroll_x = 8'(sx);
        scroll_y = 7'(sy);
`endif
        @(negedge clk);
        fs = 1'b0;
        ls = 1'b0;
        ye = (ly + sy) % 128;
        ma = (ye / 8) * 32 + (sx / 8) % 32;
        check("map_addr", 32'(map_addr), 32'(ma));
        if (is_frame) check("frame_clears_underrun", 32'(underrun), 0);
        @(negedge clk);
        check("tile_addr", 32'(tile_addr), 32'(map_mem[ma]) * 8 + 32'(ye % 8));
        repeat (6) @(negedge clk);
    endtask

    task automatic run_pixels(input int n, input int max_gap);
        int gap;
        for (int i = 0; i < n; i++) begin
            pix_en = 1'b1;
            @(negedge clk);
            pix_en = 1'b0;
            check("pixel_valid", 32'(pixel_valid), 1);
            check($sformatf("pixel[%0d] y=%0d", i, ly), 32'(pixel), exp_pix(i));
            gap = $urandom_range(max_gap, 0);
            repeat (gap) begin
                @(negedge clk);
                check("pixel_valid_idle", 32'(pixel_valid), 0);
            end
        end
        check("no_underrun", 32'(underrun), 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) map_mem[i] = 8'h01;
        for (int i = 0; i < 2048; i++) tile_mem[i] = 16'hE4E4;
        repeat (2) @(negedge clk);
        check("rst_pixel", 32'(pixel), 0);
        check("rst_valid", 32'(pixel_valid), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_map_addr", 32'(map_addr), 0);
        check("rst_tile_addr", 32'(tile_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Uniform tile 1, rows E4E4: repeating 3,2,1,0.
        do_start(1'b1);
        run_pixels(16, 0);

        for (int i = 0; i < 512; i++) map_mem[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) tile_mem[i] = 16'($urandom);
        do_start(1'b1);
        run_pixels(40, 3);
        for (int k = 1; k < 37; k++) begin
            do_start(1'b0);
            run_pixels(8 + $urandom_range(16, 0), 1);
        end
        // Line 37: map row 4, tile row 5.
        do_start(1'b0);
        check("y37_map_row", 32'(ly), 37);
        run_pixels(24, 2);

        // Full-width line plus one: wraps back to column 0 pixel 0.
        do_start(1'b0);
        run_pixels(257, 0);

        // Strobe during prefetch.
        ls = 1'b1;
        ly = (ly + 1) % 128;
        @(negedge clk);
        ls = 1'b0;
        @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        check("early_valid", 32'(pixel_valid), 1);
        check("early_pixel", 32'(pixel), 0);
        check("early_underrun", 32'(underrun), 1);
        do_start(1'b1);
        run_pixels(20, 1);

        // Asynchronous reset mid-line.
        do_start(1'b0);
        run_pixels(5, 0);
        rst = 1'b1;
        #1;
        check("arst_pixel", 32'(pixel), 0);
        check("arst_valid", 32'(pixel_valid), 0);
        check("arst_underrun", 32'(underrun), 0);
        check("arst_map_addr", 32'(map_addr), 0);
        check("arst_tile_addr", 32'(tile_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        ly = 0;
        for (int i = 0; i < 4; i++) begin
            pix_en = 1'b1;
            @(negedge clk);
            check("post_rst_no_valid", 32'(pixel_valid), 0);
        end
        pix_en = 1'b0;
        do_start(1'b1);
        run_pixels(20, 1);

`ifdef TILE_RENDERER_SCROLL_EN
        // Fine and coarse scroll: first pixel col0 px3, tile row 2 on line 5.
        sx = 3;
        sy = 125;
        do_start(1'b1);
        repeat (5) do_start(1'b0);
        run_pixels(30, 1);
        for (int k = 0; k < 4; k++) begin
            sx = $urandom_range(255, 0);
            sy = $urandom_range(127, 0);
            do_start(1'b0);
            run_pixels(40, 2);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
